// File: rtl/exit_stdout_monitor.sv
// Multi-core tohost/putchar snooper: captures per-core exit codes from the RAM write
// port and merges per-core console FIFOs into one round-robin character stream.
module exit_stdout_monitor #(
  parameter int NUM_CORE      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_WIDTH = 32,
  localparam int CORE_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [NUM_CORE-1:0]                core_en_i,
  input  logic [NUM_CORE*ADDR_WIDTH-1:0]     tohost_addr_i,
  input  logic [NUM_CORE*ADDR_WIDTH-1:0]     putchar_addr_i,
  input  logic [TIMEOUT_WIDTH-1:0]           timeout_i,
  input  logic                               mem_we_i,
  input  logic [ADDR_WIDTH-1:0]              mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]              mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            mem_wstrb_i,
  output logic                               char_valid_o,
  input  logic                               char_ready_i,
  output logic [CORE_W-1:0]                  char_core_o,
  output logic [7:0]                         char_data_o,
  output logic [NUM_CORE-1:0]                exit_valid_o,
  output logic [NUM_CORE*(DATA_WIDTH-1)-1:0] exit_code_o,
  output logic [NUM_CORE-1:0]                overflow_o,
  output logic                               all_done_o,
  output logic                               pass_o,
  output logic                               timeout_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, EXIT} state_e;

  state_e                  state_q [NUM_CORE];
  state_e                  state_d [NUM_CORE];
  logic [DATA_WIDTH-2:0]   code_q  [NUM_CORE];
  logic [DATA_WIDTH-2:0]   code_d  [NUM_CORE];
  logic [PTR_W-1:0]        wptr_q  [NUM_CORE];
  logic [PTR_W-1:0]        wptr_d  [NUM_CORE];
  logic [PTR_W-1:0]        rptr_q  [NUM_CORE];
  logic [PTR_W-1:0]        rptr_d  [NUM_CORE];
  logic [PTR_W:0]          level_q [NUM_CORE];
  logic [PTR_W:0]          level_d [NUM_CORE];
  logic [7:0]              fifo_mem_q [NUM_CORE][FIFO_DEPTH];
  logic [NUM_CORE-1:0]     en_q, en_d, ovf_q, ovf_d;
  logic                    timeout_q, timeout_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CORE_W-1:0]       rr_q, rr_d;
  logic                    char_valid_q, char_valid_d;
  logic [CORE_W-1:0]       char_core_q, char_core_d;
  logic [7:0]              char_data_q, char_data_d;

  logic [DATA_WIDTH-1:0]   masked_wdata;
  logic [NUM_CORE-1:0]     th_hit, pc_hit, push, pop, avail;
  logic                    accept, load, grant_vld, run_any;
  logic [CORE_W-1:0]       grant_idx, rr_eff;
  logic [7:0]              head_data;

  always_comb begin
    for (int b = 0; b < STRB_W; b++)
      masked_wdata[8*b +: 8] = mem_wstrb_i[b] ? mem_wdata_i[8*b +: 8] : 8'h00;
    for (int i = 0; i < NUM_CORE; i++) begin
      th_hit[i] = mem_we_i && (mem_waddr_i == tohost_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
      pc_hit[i] = mem_we_i && (mem_waddr_i == putchar_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // The presented character stays in its FIFO until accepted, so a same-cycle reload
  // must look at FIFO state and pointer as they will be after that pop.
  always_comb begin
    accept = char_valid_q && char_ready_i;
    load   = !char_valid_q || accept;
    rr_eff = rr_q;
    if (accept)
      rr_eff = (int'(char_core_q) == NUM_CORE - 1) ? '0 : char_core_q + 1'b1;
    for (int i = 0; i < NUM_CORE; i++) begin
      pop[i]   = accept && !start_i && (char_core_q == CORE_W'(i));
      avail[i] = (level_q[i] - (PTR_W + 1)'(pop[i])) != '0;
    end
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CORE; i++)
      if (!grant_vld && avail[i] && CORE_W'(i) >= rr_eff) begin
        grant_vld = 1'b1;
        grant_idx = CORE_W'(i);
      end
    for (int i = 0; i < NUM_CORE; i++)
      if (!grant_vld && avail[i] && CORE_W'(i) < rr_eff) begin
        grant_vld = 1'b1;
        grant_idx = CORE_W'(i);
      end
    head_data = 8'h00;
    for (int i = 0; i < NUM_CORE; i++)
      if (grant_idx == CORE_W'(i))
        head_data = fifo_mem_q[i][rptr_q[i] + PTR_W'(pop[i])];

    rr_d         = rr_eff;
    char_valid_d = char_valid_q && !accept;
    char_core_d  = char_core_q;
    char_data_d  = char_data_q;
    if (start_i) begin
      char_valid_d = 1'b0;
    end else if (load && grant_vld) begin
      char_valid_d = 1'b1;
      char_core_d  = grant_idx;
      char_data_d  = head_data;
    end
  end

  always_comb begin
    logic push_req;
    push_req = 1'b0;
    en_d     = start_i ? core_en_i : en_q;
    ovf_d    = ovf_q;
    push     = '0;
    run_any  = 1'b0;
    for (int i = 0; i < NUM_CORE; i++) begin
      state_d[i] = state_q[i];
      code_d[i]  = code_q[i];
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      level_d[i] = level_q[i];
      if (state_q[i] == RUN) run_any = 1'b1;
      if (start_i) begin
        state_d[i] = core_en_i[i] ? RUN : IDLE;
        code_d[i]  = '0;
        ovf_d[i]   = 1'b0;
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        level_d[i] = '0;
      end else begin
        if (state_q[i] == RUN && th_hit[i] && !timeout_q && masked_wdata[0]) begin
          state_d[i] = EXIT;
          code_d[i]  = masked_wdata[DATA_WIDTH-1:1];
        end
        // A tohost hit shadows a putchar hit on the same core even when the exit is ignored.
        push_req = (state_q[i] == RUN) && pc_hit[i] && !th_hit[i] && mem_wstrb_i[0];
        push[i]  = push_req && ((level_q[i] != FULL_LEVEL) || pop[i]);
        if (push_req && !push[i]) ovf_d[i] = 1'b1;
        wptr_d[i]  = wptr_q[i] + PTR_W'(push[i]);
        rptr_d[i]  = rptr_q[i] + PTR_W'(pop[i]);
        level_d[i] = level_q[i] + (PTR_W + 1)'(push[i]) - (PTR_W + 1)'(pop[i]);
      end
    end

    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (start_i) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (run_any && !timeout_q) begin
      cnt_d = cnt_q + 1'b1;
      if (timeout_i != '0 && cnt_d == timeout_i) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q         <= '0;
      ovf_q        <= '0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      rr_q         <= '0;
      char_valid_q <= 1'b0;
      char_core_q  <= '0;
      char_data_q  <= '0;
      for (int i = 0; i < NUM_CORE; i++) begin
        state_q[i] <= IDLE;
        code_q[i]  <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        level_q[i] <= '0;
      end
    end else begin
      en_q         <= en_d;
      ovf_q        <= ovf_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      char_valid_q <= char_valid_d;
      char_core_q  <= char_core_d;
      char_data_q  <= char_data_d;
      for (int i = 0; i < NUM_CORE; i++) begin
        state_q[i] <= state_d[i];
        code_q[i]  <= code_d[i];
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        level_q[i] <= level_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CORE; i++)
      if (push[i]) fifo_mem_q[i][wptr_q[i]] <= mem_wdata_i[7:0];
  end

  always_comb begin
    logic done, codes_zero;
    done       = (en_q != '0);
    codes_zero = 1'b1;
    for (int i = 0; i < NUM_CORE; i++) begin
      exit_valid_o[i] = (state_q[i] == EXIT);
      exit_code_o[i*(DATA_WIDTH-1) +: DATA_WIDTH-1] = code_q[i];
      if (en_q[i] && state_q[i] != EXIT) done = 1'b0;
      if (code_q[i] != '0) codes_zero = 1'b0;
    end
    all_done_o   = done;
    pass_o       = done && codes_zero && (ovf_q == '0) && !timeout_q;
    overflow_o   = ovf_q;
    timeout_o    = timeout_q;
    char_valid_o = char_valid_q;
    char_core_o  = char_core_q;
    char_data_o  = char_data_q;
  end
endmodule
